cf_fft_1024_8_slot_writer: RTL

CF_FFT_1024_8_SLOT_WRITER -- requirements
Module: cf_fft_1024_8_slot_writer

---
 rtl/cf_fft_1024_8_slot_writer.sv | 89 ++++++++
 1 files changed

// File: rtl/cf_fft_1024_8_slot_writer.sv
// Eight-slot frame collector: fills slots from an input stream, then holds the frame
// until the consumer takes it. A sync sample restarts the frame at slot 0.
module cf_fft_1024_8_slot_writer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clock_c,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 valid_i,
  input  logic                 sync_i,
  input  logic [WIDTH-1:0]     data_i,
  output logic                 ready_o,
  output logic [8*WIDTH-1:0]   frame_o,
  output logic                 frame_valid_o,
  input  logic                 frame_ready_i,
  output logic [2:0]           index_o,
  output logic                 sync_err_o,
  output logic                 overflow_o
);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] slot_q [8];
  logic [2:0]       index_q;
  logic             frame_valid_q;
  logic             sync_err_q;
  logic             overflow_q;

  assign ready_o       = enable_i & (state_q == StFill);
  assign index_o       = index_q;
  assign frame_valid_o = frame_valid_q;
  assign sync_err_o    = sync_err_q;
  assign overflow_o    = overflow_q;

  always_comb begin
    frame_o = '0;
    for (int k = 0; k < 8; k++) begin
      frame_o[WIDTH*k +: WIDTH] = slot_q[k];
    end
  end

  always_ff @(posedge clock_c) begin
    if (!reset_i) begin
      state_q       <= StFill;
      index_q       <= 3'd0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      overflow_q    <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      // The resync error is a single-cycle pulse, so it drops even while disabled.
      sync_err_q <= 1'b0;
      if (enable_i) begin
        if (valid_i && (state_q != StFill)) begin
          overflow_q <= 1'b1;
        end
        unique case (state_q)
          StFill: begin
            if (valid_i) begin
              if (sync_i) begin
                slot_q[0]  <= data_i;
                index_q    <= 3'd1;
                sync_err_q <= (index_q != 3'd0);
              end else begin
                slot_q[index_q] <= data_i;
                index_q         <= index_q + 3'd1;
                if (index_q == 3'd7) begin
                  state_q       <= StHold;
                  frame_valid_q <= 1'b1;
                end
              end
            end
          end
          StHold: begin
            if (frame_valid_q && frame_ready_i) begin
              state_q       <= StFill;
              frame_valid_q <= 1'b0;
            end
          end
          default: state_q <= StFill;
        endcase
      end
    end
  end

endmodule
